pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Pipeline latch controller at the consuming end of the hazard unit interface. Takes `disable_fetch`, `flush2` and `flush3` from the hazard unit, plus cache hit and memory-request status. Drives per-stage enable and flush strobes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, masks data-memory requests so each is issued exactly once, and sequences processor halt. It sits in the datapath top beside the hazard unit and feeds every pipeline latch.

## Interface
Parameters:
- `CNT_W`, 32: width of the performance counters.

Ports:
- `CLK` in 1: system clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `disable_fetch` in 1: load-use stall request from the hazard unit.
- `flush2` in 1: flush IF/ID (branch or jump taken).
- `flush3` in 1: flush ID/EX.
- `ihit` in 1: instruction cache hit this cycle.
- `dhit` in 1: data cache hit this cycle.
- `mem_dren`, `mem_dwen` in 1 each: read and write requests of the instruction in EX/MEM.
- `wb_halt` in 1: halt instruction present in MEM/WB.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1 each: latch enables.
- `ifid_flush`, `idex_flush` out 1 each: synchronous clear of the latch; only meaningful with its enable.
- `dmem_ren`, `dmem_wen` out 1 each: masked requests to the data cache.
- `halt` out 1: processor halted (sticky).
- `stall_cycles` out CNT_W: cycles with no advance.
- `flush_count` out CNT_W: hazard flushes applied.

## Operation
- States: RUN, MEMDONE, HALT. Registered flags `pend2` and `pend3`.
- `memop = mem_dren | mem_dwen`.
- Advance signal:
  - RUN: `adv = ihit & (!memop | dhit)`.
  - MEMDONE: `adv = ihit`.
  - HALT: `adv = 0`.
  - `adv` is forced to 0 in any cycle where `wb_halt` or `RST` is high.
- Effective flushes: `f2 = flush2 | pend2` and `f3 = flush3 | pend3`.
- Enables:
  - `memwb_en = exmem_en = idex_en = adv`.
  - `pc_en = ifid_en = adv & (!disable_fetch | f2)`. A flush overrides a load-use hold, so the branch target is loaded.
- Flushes:
  - `ifid_flush = adv & f2`.
  - `idex_flush = adv & (f3 | disable_fetch)`. This inserts the bubble for load-use.
- Data-memory masking: `dmem_ren = mem_dren` and `dmem_wen = mem_dwen` only in RUN with `wb_halt` and `RST` low; otherwise 0. This prevents a duplicate access after `dhit`.
- Transitions:
  - RUN to MEMDONE when `memop & dhit & !ihit`.
  - MEMDONE to RUN when `ihit`.
  - Any state to HALT when `wb_halt`; this has highest priority below `RST`.
  - HALT is left only by `RST`.
- Pending flushes:
  - `pendN` sets when `flushN & !adv`.
  - `pendN` clears on any cycle with `adv`.
  - Set and clear in the same cycle resolves to clear, because the flush is applied that cycle.
- HALT: all enables, flushes and dmem requests are 0; `halt = 1`.
- Reset: state RUN, `pend2 = pend3 = 0`, `halt = 0`, counters 0. While `RST` is high, all combinational outputs are 0.

## Timing
- Enables, flushes and dmem requests are combinational from current inputs and state, with 0-cycle latency.
- `halt` is registered: it rises 1 cycle after `wb_halt` is sampled high.
- `stall_cycles` increments on each cycle with state not HALT, `RST` low and `adv = 0`.
- `flush_count` increments by 1 on each cycle with `adv & (f2 | f3)`. A simultaneous f2 and f3 counts once. `disable_fetch` bubbles are not counted.
- Both counters saturate at all-ones and never wrap.
- `dhit` without `memop` is ignored.
- `ihit` and `dhit` arriving together from RUN advance with no state change.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: the performance counters are compiled in and operate as specified.
- Undefined: counter logic is removed; `stall_cycles` and `flush_count` ports remain and are tied to 0. All other behaviour is identical.

## Structure
- `pctrl_state_t` (RUN, MEMDONE, HALT) enum belongs in `cpu_types_pkg`.
- One sub-module, `pipeline_ctrl_perf`: holds both saturating counters with CNT_W parameter, instantiated only under the macro.

## Test plan
- Reset, then `ihit = 1` with no hazards: all five enables 1, flushes 0; `stall_cycles` stays 0 over 10 cycles.
- `mem_dren = 1`, `ihit = 1`, `dhit = 0` for 3 cycles, then `dhit = 1`: enables 0 for 3 cycles and 1 on the 4th; `dmem_ren = 1` throughout; `stall_cycles = 3`.
- `mem_dwen = 1`, `dhit = 1`, `ihit = 0`, then `ihit` low for 2 more cycles, then high:
  - state goes to MEMDONE;
  - `dmem_wen = 0` during MEMDONE;
  - advance occurs on the cycle `ihit` rises;
  - state returns to RUN.
- `flush2 = 1` for one cycle while `ihit = 0`, then `ihit = 1` with `flush2 = 0`: `ifid_flush = 1` and `pc_en = 1` on the advancing cycle; `flush_count = 1`.
- `disable_fetch = 1` with `ihit = 1`: `pc_en = ifid_en = 0`, `idex_flush = 1`. Adding `flush2 = 1`: `pc_en = ifid_en = ifid_flush = 1`.
- `wb_halt = 1` mid-run: all enables 0 the same cycle; `halt = 1` next cycle and stays 1 for 20 cycles; `RST` pulse returns `halt` to 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU control types; holds the pipeline controller state encoding.
`default_nettype none

package cpu_types_pkg;

  localparam int PCTRL_STATE_W = 2;

  typedef enum logic [PCTRL_STATE_W-1:0] {
    RUN     = 2'd0,
    MEMDONE = 2'd1,
    HALT    = 2'd2
  } pctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_perf.sv
// pipeline_ctrl_perf: saturating stall-cycle and hazard-flush counters.
`default_nettype none

module pipeline_ctrl_perf #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_inc_i,
  input  logic             flush_inc_i,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
);

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Counters hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc_i && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc_i && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles_o = stall_q;
  assign flush_count_o  = flush_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: pipeline latch enables/flushes, one-shot dmem masking and halt sequencing.
// Define PIPE_CTRL_PERF_EN to build the stall/flush performance counters (tied to 0 otherwise).
`default_nettype none

module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             disable_fetch,
  input  logic             flush2,
  input  logic             flush3,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             dmem_ren,
  output logic             dmem_wen,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  pctrl_state_t state_q, state_d;
  logic         pend2_q, pend2_d;
  logic         pend3_q, pend3_d;
  logic         halt_q;

  logic w_memop;
  logic w_adv;
  logic w_f2;
  logic w_f3;

  assign w_memop = mem_dren | mem_dwen;
  assign w_f2    = flush2 | pend2_q;
  assign w_f3    = flush3 | pend3_q;

  always_comb begin
    w_adv = 1'b0;
    case (state_q)
      RUN:     w_adv = ihit & (~w_memop | dhit);
      MEMDONE: w_adv = ihit;
      default: w_adv = 1'b0;
    endcase
    if (wb_halt || RST) w_adv = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      pend2_q <= 1'b0;
      pend3_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend2_q <= pend2_d;
      pend3_q <= pend3_d;
      halt_q  <= halt_q | wb_halt;
    end
  end

  // A flush seen while stalled is remembered until the next advance applies it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (w_memop && dhit && !ihit) state_d = MEMDONE;
      MEMDONE: if (ihit) state_d = RUN;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
    if (wb_halt) state_d = HALT;

    pend2_d = w_adv ? 1'b0 : (pend2_q | flush2);
    pend3_d = w_adv ? 1'b0 : (pend3_q | flush3);
  end

  always_comb begin
    memwb_en   = w_adv;
    exmem_en   = w_adv;
    idex_en    = w_adv;
    pc_en      = w_adv & (~disable_fetch | w_f2);
    ifid_en    = w_adv & (~disable_fetch | w_f2);
    ifid_flush = w_adv & w_f2;
    idex_flush = w_adv & (w_f3 | disable_fetch);
    dmem_ren   = 1'b0;
    dmem_wen   = 1'b0;
    // MEMDONE means the access already hit; re-issuing it would duplicate a store.
    if ((state_q == RUN) && !wb_halt && !RST) begin
      dmem_ren = mem_dren;
      dmem_wen = mem_dwen;
    end
  end

  assign halt = halt_q;

`ifdef PIPE_CTRL_PERF_EN
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_stall_inc = (state_q != HALT) & ~RST & ~w_adv;
  assign w_flush_inc = w_adv & (w_f2 | w_f3);

  pipeline_ctrl_perf #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk            (CLK),
    .rst            (RST),
    .stall_inc_i    (w_stall_inc),
    .flush_inc_i    (w_flush_inc),
    .stall_cycles_o (stall_cycles),
    .flush_count_o  (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl; counter checks follow PIPE_CTRL_PERF_EN.
`default_nettype none

module tb_pipeline_ctrl;

  localparam int CNT_W = 32;

  // Stimulus bits {disable_fetch, flush2, flush3, ihit, dhit, mem_dren, mem_dwen, wb_halt}
  localparam logic [7:0] NONE = 8'h00;
  localparam logic [7:0] DF   = 8'h80;
  localparam logic [7:0] F2   = 8'h40;
  localparam logic [7:0] F3   = 8'h20;
  localparam logic [7:0] IH   = 8'h10;
  localparam logic [7:0] DH   = 8'h08;
  localparam logic [7:0] DR   = 8'h04;
  localparam logic [7:0] DW   = 8'h02;
  localparam logic [7:0] WH   = 8'h01;

  // Output bits {pc,ifid,idex,exmem,memwb, ifid_flush, idex_flush, dmem_ren, dmem_wen, halt}
  localparam logic [9:0] E_0    = 10'h000;
  localparam logic [9:0] E_ALL  = 10'h3E0;
  localparam logic [9:0] E_BACK = 10'h0E0;
  localparam logic [9:0] E_IFF  = 10'h010;
  localparam logic [9:0] E_IDF  = 10'h008;
  localparam logic [9:0] E_DR   = 10'h004;
  localparam logic [9:0] E_DW   = 10'h002;
  localparam logic [9:0] E_H    = 10'h001;

  logic             CLK;
  logic             RST;
  logic             disable_fetch, flush2, flush3, ihit, dhit;
  logic             mem_dren, mem_dwen, wb_halt;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, dmem_ren, dmem_wen, halt;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] exp_q [$];

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .disable_fetch (disable_fetch),
    .flush2        (flush2),
    .flush3        (flush3),
    .ihit          (ihit),
    .dhit          (dhit),
    .mem_dren      (mem_dren),
    .mem_dwen      (mem_dwen),
    .wb_halt       (wb_halt),
    .pc_en         (pc_en),
    .ifid_en       (ifid_en),
    .idex_en       (idex_en),
    .exmem_en      (exmem_en),
    .memwb_en      (memwb_en),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .dmem_ren      (dmem_ren),
    .dmem_wen      (dmem_wen),
    .halt          (halt),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic apply(input logic [7:0] s);
    {disable_fetch, flush2, flush3, ihit, dhit, mem_dren, mem_dwen, wb_halt} = s;
  endtask

  function automatic logic [9:0] outs();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_flush, idex_flush, dmem_ren, dmem_wen, halt};
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt(input int v);
`ifdef PIPE_CTRL_PERF_EN
    return CNT_W'(v);
`else
    return (v == 0) ? '0 : '0;
`endif
  endfunction

  // Leaves the bench at a falling edge with RST low, ready to apply the first row.
  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    apply(NONE);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] got, exp;
    RST = 1'b1;
    apply(IH | DR | DW | F2 | F3);
    repeat (2) @(negedge CLK);
    exp_q.push_back(E_0);
    #1;
    got = outs();
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_outs: got %b expected %b", got, exp);
    end
    n_checks++;
    if (stall_cycles !== '0 || flush_count !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt: got stall=%0d flush=%0d expected 0/0", stall_cycles, flush_count);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_run();
    logic [9:0] got, exp;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      apply(IH);
      exp_q.push_back(E_ALL);
      #1;
      got = outs();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL run[%0d]: got %b expected %b", i, got, exp);
      end
      @(negedge CLK);
    end
    apply(IH);
    #1;
    n_checks++;
    if (stall_cycles !== exp_cnt(0)) begin
      n_fail++;
      $display("FAIL run_stall: got %0d expected %0d", stall_cycles, exp_cnt(0));
    end
    @(negedge CLK);
  endtask

  task automatic test_dmem_read();
    logic [17:0] rows [4];
    logic [9:0]  got, exp;
    rows = '{{IH | DR, E_DR}, {IH | DR, E_DR}, {IH | DR, E_DR}, {IH | DR | DH, E_ALL | E_DR}};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(rows[i][17:10]);
      exp_q.push_back(rows[i][9:0]);
      #1;
      got = outs();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL dmem_read[%0d]: got %b expected %b", i, got, exp);
      end
      @(negedge CLK);
    end
    apply(IH);
    #1;
    n_checks++;
    if (stall_cycles !== exp_cnt(3)) begin
      n_fail++;
      $display("FAIL dmem_read_stall: got %0d expected %0d", stall_cycles, exp_cnt(3));
    end
    @(negedge CLK);
  endtask

  task automatic test_memdone();
    logic [17:0] rows [5];
    logic [9:0]  got, exp;
    // Write hits without ihit, waits in MEMDONE, advances on ihit, then back in RUN.
    rows = '{{DW | DH, E_DW}, {DW, E_0}, {DW, E_0}, {DW | IH, E_ALL}, {DW | IH, E_DW}};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(rows[i][17:10]);
      exp_q.push_back(rows[i][9:0]);
      #1;
      got = outs();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL memdone[%0d]: got %b expected %b", i, got, exp);
      end
      @(negedge CLK);
    end
    apply(IH);
    #1;
    n_checks++;
    if (stall_cycles !== exp_cnt(4)) begin
      n_fail++;
      $display("FAIL memdone_stall: got %0d expected %0d", stall_cycles, exp_cnt(4));
    end
    @(negedge CLK);
  endtask

  task automatic test_flush();
    logic [17:0] rows [7];
    logic [9:0]  got, exp;
    rows = '{{F2, E_0}, {IH, E_ALL | E_IFF}, {IH, E_ALL},
             {F3, E_0}, {IH, E_ALL | E_IDF},
             {IH | F2 | F3, E_ALL | E_IFF | E_IDF}, {IH, E_ALL}};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(rows[i][17:10]);
      exp_q.push_back(rows[i][9:0]);
      #1;
      got = outs();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL flush[%0d]: got %b expected %b", i, got, exp);
      end
      @(negedge CLK);
    end
    apply(IH);
    #1;
    n_checks++;
    if (flush_count !== exp_cnt(3)) begin
      n_fail++;
      $display("FAIL flush_count: got %0d expected %0d", flush_count, exp_cnt(3));
    end
    @(negedge CLK);
  endtask

  task automatic test_load_use();
    logic [17:0] rows [4];
    logic [9:0]  got, exp;
    rows = '{{DF | IH, E_BACK | E_IDF}, {DF, E_0},
             {DF | F2 | IH, E_ALL | E_IFF | E_IDF}, {IH, E_ALL}};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(rows[i][17:10]);
      exp_q.push_back(rows[i][9:0]);
      #1;
      got = outs();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL load_use[%0d]: got %b expected %b", i, got, exp);
      end
      @(negedge CLK);
    end
    apply(IH);
    #1;
    n_checks++;
    if (flush_count !== exp_cnt(1)) begin
      n_fail++;
      $display("FAIL load_use_flush_count: got %0d expected %0d", flush_count, exp_cnt(1));
    end
    @(negedge CLK);
  endtask

  task automatic test_halt();
    logic [17:0] rows [23];
    logic [9:0]  got, exp;
    rows[0] = {IH, E_ALL};
    rows[1] = {IH, E_ALL};
    rows[2] = {WH | IH | DR, E_0};
    for (int i = 3; i < 23; i++) rows[i] = {IH | DR | DH | F2, E_H};
    do_reset();
    for (int i = 0; i < 23; i++) begin
      apply(rows[i][17:10]);
      exp_q.push_back(rows[i][9:0]);
      #1;
      got = outs();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL halt[%0d]: got %b expected %b", i, got, exp);
      end
      @(negedge CLK);
    end
    apply(IH);
    #1;
    n_checks++;
    if (stall_cycles !== exp_cnt(1)) begin
      n_fail++;
      $display("FAIL halt_stall: got %0d expected %0d", stall_cycles, exp_cnt(1));
    end
    do_reset();
    apply(IH);
    exp_q.push_back(E_ALL);
    #1;
    got = outs();
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL halt_release: got %b expected %b", got, exp);
    end
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1;
    apply(NONE);
    test_reset();
    test_run();
    test_dmem_read();
    test_memdone();
    test_flush();
    test_load_use();
    test_halt();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
